vec_sequencer: RTL

VEC_SEQUENCER -- requirements
Module: vec_sequencer

---
 rtl/vp_pkg.sv | 40 ++++
 rtl/vseq_idx_counter.sv | 44 ++++
 rtl/vec_sequencer.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/vp_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : vp_pkg
//  Purpose  : Shared definitions for the vector operation sequencer:
//             sequencer state enum, op_code constants, the op_code bit that
//             marks a store, and the illegal-operation decode helper.
//  Revision : 1.0  initial release
// ============================================================================
package vp_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        EXEC  = 3'd2,
        WRITE = 3'd3,
        DONE  = 3'd4
    } state_t;

    // ALU op_code values (instruction bits 19:17 when funct = 0)
    localparam logic [2:0] MOV_IMM    = 3'b000;
    localparam logic [2:0] MOV_SV     = 3'b001;
    localparam logic [2:0] ADD_S      = 3'b010;
    localparam logic [2:0] SUB_S      = 3'b011;
    localparam logic [2:0] MUL_VS     = 3'b100;
    localparam logic [2:0] ADD_VV     = 3'b101;
    localparam logic [2:0] DIV_VS     = 3'b110;
    localparam logic [2:0] OP_ILLEGAL = 3'b111;

    // For load/store ops (funct = 1) this op_code bit selects store
    localparam int STORE_BIT = 0;

    // Only ALU encodings can be illegal; every load/store encoding is valid.
    function automatic logic is_illegal(input logic       funct,
                                        input logic [2:0] code,
                                        input logic       div_en);
        return !funct && ((code == OP_ILLEGAL) || ((code == DIV_VS) && !div_en));
    endfunction

endpackage
`default_nettype wire

// File: rtl/vseq_idx_counter.sv
`default_nettype none
// ============================================================================
//  Module   : vseq_idx_counter
//  Purpose  : Element index counter for the vector sequencer.
//  Ports    : clk, rst      - clock, asynchronous active-high reset
//             clear         - return index to 0 (operation accepted)
//             incr          - advance to the next element
//             vec_mode      - 1: VLEN elements, 0: single element
//             idx           - current element index
//             last          - current element is the final one
//  Revision : 1.0  initial release
// ============================================================================
module vseq_idx_counter #(
    parameter int VLEN  = 8,
    parameter int IDX_W = $clog2(VLEN)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             incr,
    input  logic             vec_mode,
    output logic [IDX_W-1:0] idx,
    output logic             last
);

    localparam logic [IDX_W-1:0] C_LAST_VEC = IDX_W'(VLEN - 1);

    logic [IDX_W-1:0] r_idx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx <= '0;
        end else if (clear) begin
            r_idx <= '0;
        end else if (incr) begin
            r_idx <= r_idx + 1'b1;
        end
    end

    assign idx  = r_idx;
    assign last = vec_mode ? (r_idx == C_LAST_VEC) : (r_idx == '0);

endmodule
`default_nettype wire

// File: rtl/vec_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : vec_sequencer
//  Purpose  : Sequences one decoded vector/scalar operation element by
//             element through FETCH -> EXEC -> WRITE, then pulses done.
//  Config   : define VSEQ_DIV_EN to support divide (op_code 110); without
//             it divide decodes as illegal.
//  Ports    : clk, rst              - clock, asynchronous active-high reset
//             op_valid / op_ready   - operation handshake (ready only in IDLE)
//             op_funct, op_code     - instruction bits 20 and 19:17
//             op_dest_vec           - destination is a vector register
//             alu_done, mem_ack     - divider / data memory completion
//             rf_rd_en, alu_go      - register read strobe, ALU start pulse
//             mem_req, wb_en        - memory request, write-back strobe
//             elem_idx              - current element index
//             busy, done, err       - stall, completion pulse, illegal pulse
//  Revision : 1.0  initial release
// ============================================================================
module vec_sequencer
    import vp_pkg::*;
#(
    parameter int VLEN  = 8,
    parameter int IDX_W = $clog2(VLEN)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic             op_funct,
    input  logic [2:0]       op_code,
    input  logic             op_dest_vec,
    input  logic             alu_done,
    input  logic             mem_ack,
    output logic             rf_rd_en,
    output logic             alu_go,
    output logic             mem_req,
    output logic             wb_en,
    output logic [IDX_W-1:0] elem_idx,
    output logic             busy,
    output logic             done,
    output logic             err
);

`ifdef VSEQ_DIV_EN
    localparam logic C_DIV_EN = 1'b1;
`else
    localparam logic C_DIV_EN = 1'b0;
`endif

    state_t     r_state;
    state_t     w_next;
    logic       r_funct;
    logic [2:0] r_code;
    logic       r_vec;
    logic       r_exec_first;
    logic       r_err;

    logic       w_accept;
    logic       w_illegal;
    logic       w_is_store;
    logic       w_is_div;
    logic       w_last;
    logic       w_incr;

    assign w_accept   = (r_state == IDLE) && op_valid;
    assign w_illegal  = is_illegal(op_funct, op_code, C_DIV_EN);
    assign w_is_store = r_funct && r_code[STORE_BIT];
    assign w_is_div   = C_DIV_EN && !r_funct && (r_code == DIV_VS);

    vseq_idx_counter #(
        .VLEN  (VLEN),
        .IDX_W (IDX_W)
    ) u_idx (
        .clk      (clk),
        .rst      (rst),
        .clear    (w_accept),
        .incr     (w_incr),
        .vec_mode (r_vec),
        .idx      (elem_idx),
        .last     (w_last)
    );

    // State and latched operation fields. An illegal op is still accepted
    // (fields latched, index cleared) but the FSM never leaves IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_funct      <= 1'b0;
            r_code       <= 3'b000;
            r_vec        <= 1'b0;
            r_exec_first <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_state      <= w_next;
            // EXEC is always entered from FETCH, so this marks its first cycle
            r_exec_first <= (r_state == FETCH);
            r_err        <= w_accept && w_illegal;
            if (w_accept) begin
                r_funct <= op_funct;
                r_code  <= op_code;
                r_vec   <= op_dest_vec;
            end
        end
    end

    always_comb begin
        w_next   = r_state;
        op_ready = 1'b0;
        rf_rd_en = 1'b0;
        alu_go   = 1'b0;
        mem_req  = 1'b0;
        wb_en    = 1'b0;
        done     = 1'b0;
        w_incr   = 1'b0;
        case (r_state)
            IDLE: begin
                op_ready = 1'b1;
                if (op_valid && !w_illegal) begin
                    w_next = FETCH;
                end
            end
            FETCH: begin
                rf_rd_en = 1'b1;
                w_next   = EXEC;
            end
            EXEC: begin
                if (r_funct) begin
                    mem_req = 1'b1;
                    if (mem_ack) begin
                        w_next = WRITE;
                    end
                end else begin
                    alu_go = r_exec_first;
                    // Only a divide waits for the ALU; others take one cycle
                    if (!w_is_div || alu_done) begin
                        w_next = WRITE;
                    end
                end
            end
            WRITE: begin
                wb_en = !w_is_store;
                if (w_last) begin
                    w_next = DONE;
                end else begin
                    w_incr = 1'b1;
                    w_next = FETCH;
                end
            end
            DONE: begin
                done   = 1'b1;
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    assign busy = (r_state != IDLE);
    assign err  = r_err;

endmodule
`default_nettype wire
